// File: rtl/aes_job_sequencer.sv
// Drives the aes core register port to run one 128-bit block job per request.
// Optional build macro AES_SEQ_KEY_CACHE_EN skips key programming when the key is unchanged.
module aes_job_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LAT     = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [255:0]          req_key_i,
  input  logic                  req_keylen_i,
  input  logic                  req_encdec_i,
  input  logic [127:0]          req_block_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [127:0]          rsp_block_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  aes_cs_o,
  output logic                  aes_we_o,
  output logic [ADDR_WIDTH-1:0] aes_addr_o,
  output logic [31:0]           aes_wdata_o,
  input  logic [31:0]           aes_rdata_i
);

  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h09;
  localparam logic [7:0] A_CONFIG = 8'h0A;
  localparam logic [7:0] A_KEY    = 8'h10;
  localparam logic [7:0] A_BLOCK  = 8'h20;
  localparam logic [7:0] A_RESULT = 8'h30;
  localparam int         PW       = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_KEY, S_INIT, S_WAIT_KEY, S_BLK, S_NEXT, S_WAIT_RES, S_RES, S_DONE
  } state_t;

  state_t          state;
  logic [255:0]    key_q;
  logic            keylen_q;
  logic            encdec_q;
  logic [127:0]    block_q;
  logic [2:0]      idx;
  logic [1:0]      res_cnt;
  logic [PW-1:0]   poll_cnt;
  logic            rd_pend;
  logic [RD_LAT-1:0] rd_pipe;
  logic            rd_sample;
  logic            poll_hit;
  logic            key_hit;

  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [7:0] a);
    return ADDR_WIDTH'(a);
  endfunction

`ifdef AES_SEQ_KEY_CACHE_EN
  logic [255:0] cache_key;
  logic         cache_keylen;
  logic         key_loaded;

  // AES-128 only programs the upper half, so the lower half must not affect the match
  assign key_hit = key_loaded && (cache_keylen == keylen_q) &&
                   (cache_key[255:128] == key_q[255:128]) &&
                   (!keylen_q || (cache_key[127:0] == key_q[127:0]));
`else
  assign key_hit = 1'b0;
`endif

  // rd_pipe tracks each read strobe on the bus until its data is due on aes_rdata_i
  assign rd_sample = rd_pipe[RD_LAT-1];
  assign poll_hit  = (state == S_WAIT_KEY) ? aes_rdata_i[0] : aes_rdata_i[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_block_o <= '0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
      aes_cs_o    <= 1'b0;
      aes_we_o    <= 1'b0;
      aes_addr_o  <= '0;
      aes_wdata_o <= '0;
      idx         <= '0;
      res_cnt     <= '0;
      poll_cnt    <= '0;
      rd_pend     <= 1'b0;
      rd_pipe     <= '0;
`ifdef AES_SEQ_KEY_CACHE_EN
      key_loaded  <= 1'b0;
`endif
    end else begin
      aes_cs_o <= 1'b0;
      aes_we_o <= 1'b0;
      rd_pipe  <= (rd_pipe << 1) | RD_LAT'(aes_cs_o & ~aes_we_o);
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            key_q       <= req_key_i;
            keylen_q    <= req_keylen_i;
            encdec_q    <= req_encdec_i;
            block_q     <= req_block_i;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_block_o <= '0;
            state       <= S_CFG;
          end
        end
        S_CFG: begin
          aes_cs_o    <= 1'b1;
          aes_we_o    <= 1'b1;
          aes_addr_o  <= reg_addr(A_CONFIG);
          aes_wdata_o <= {30'b0, keylen_q, encdec_q};
          idx         <= '0;
          state       <= key_hit ? S_BLK : S_KEY;
        end
        S_KEY: begin
          aes_cs_o    <= 1'b1;
          aes_we_o    <= 1'b1;
          aes_addr_o  <= reg_addr(A_KEY + {5'd0, idx});
          aes_wdata_o <= key_q[{3'd7 - idx, 5'd0} +: 32];
          if (idx == (keylen_q ? 3'd7 : 3'd3)) begin
            idx   <= '0;
            state <= S_INIT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_INIT, S_NEXT: begin
          aes_cs_o    <= 1'b1;
          aes_we_o    <= 1'b1;
          aes_addr_o  <= reg_addr(A_CTRL);
          aes_wdata_o <= (state == S_INIT) ? 32'h1 : 32'h2;
          poll_cnt    <= '0;
          rd_pend     <= 1'b0;
          state       <= (state == S_INIT) ? S_WAIT_KEY : S_WAIT_RES;
        end
        S_WAIT_KEY, S_WAIT_RES: begin
          if (!rd_pend) begin
            aes_cs_o   <= 1'b1;
            aes_addr_o <= reg_addr(A_STATUS);
            poll_cnt   <= poll_cnt + 1'b1;
            rd_pend    <= 1'b1;
          end else if (rd_sample) begin
            rd_pend <= 1'b0;
            if (poll_hit) begin
              idx     <= '0;
              res_cnt <= '0;
              state   <= (state == S_WAIT_KEY) ? S_BLK : S_RES;
`ifdef AES_SEQ_KEY_CACHE_EN
              if (state == S_WAIT_KEY) begin
                cache_key    <= key_q;
                cache_keylen <= keylen_q;
                key_loaded   <= 1'b1;
              end
`endif
            end else if (poll_cnt == PW'(TIMEOUT)) begin
              rsp_err_o   <= 1'b1;
              rsp_block_o <= '0;
              rsp_valid_o <= 1'b1;
              state       <= S_DONE;
`ifdef AES_SEQ_KEY_CACHE_EN
              key_loaded  <= 1'b0;
`endif
            end
          end
        end
        S_BLK: begin
          aes_cs_o    <= 1'b1;
          aes_we_o    <= 1'b1;
          aes_addr_o  <= reg_addr(A_BLOCK + {6'd0, idx[1:0]});
          aes_wdata_o <= block_q[{2'd3 - idx[1:0], 5'd0} +: 32];
          if (idx == 3'd3) begin
            idx   <= '0;
            state <= S_NEXT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_RES: begin
          if (!idx[2]) begin
            aes_cs_o   <= 1'b1;
            aes_addr_o <= reg_addr(A_RESULT + {6'd0, idx[1:0]});
            idx        <= idx + 3'd1;
          end
          // Reads return in issue order, so shifting in leaves RESULT0 in the top word
          if (rd_sample) begin
            rsp_block_o <= {rsp_block_o[95:0], aes_rdata_i};
            res_cnt     <= res_cnt + 2'd1;
            if (res_cnt == 2'd3) begin
              rsp_valid_o <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed bench for aes_job_sequencer with a behavioural aes register-port model.
// Build with or without AES_SEQ_KEY_CACHE_EN; key-reuse expectations follow the macro.
module tb_aes_job_sequencer;

  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] BLK2  = 128'hdeadbeef0123456789abcdefcafef00d;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [255:0] req_key_i = '0;
  logic         req_keylen_i = 1'b0;
  logic         req_encdec_i = 1'b0;
  logic [127:0] req_block_i = '0;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic [127:0] rsp_block_o;
  logic         rsp_err_o;
  logic         busy_o;
  logic         aes_cs_o;
  logic         aes_we_o;
  logic [31:0]  aes_addr_o;
  logic [31:0]  aes_wdata_o;
  logic [31:0]  aes_rdata_i = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  aes_job_sequencer #(.ADDR_WIDTH(32), .RD_LAT(1), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_key_i(req_key_i), .req_keylen_i(req_keylen_i),
    .req_encdec_i(req_encdec_i), .req_block_i(req_block_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_block_o(rsp_block_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .aes_cs_o(aes_cs_o), .aes_we_o(aes_we_o), .aes_addr_o(aes_addr_o),
    .aes_wdata_o(aes_wdata_o), .aes_rdata_i(aes_rdata_i)
  );

  // Core model: registered read data, busy for 3 cycles after init/next
  logic [31:0]  m_key [8] = '{default: 32'h0};
  logic [31:0]  m_blk [4] = '{default: 32'h0};
  logic [1:0]   m_cfg = 2'b00;
  logic [127:0] m_res = '0;
  logic         m_valid = 1'b0;
  logic         m_stuck = 1'b0;
  int           m_busy = 0;
  int           n_key_wr = 0, n_init = 0, n_cfg_wr = 0, n_status_rd = 0, n_acc = 0;
  logic [31:0]  last_cfg = '0;

  function automatic logic [127:0] aes_ref(input logic [1:0] cfg, input logic [255:0] k,
                                           input logic [127:0] b);
    if (cfg == 2'b01 && k[255:128] == K128 && b == PT) return CT128;
    if (cfg == 2'b10 && k == K256 && b == CT256) return PT;
    return b ^ k[255:128];
  endfunction

  always @(posedge clk_i) begin
    if (m_busy > 0) m_busy <= m_busy - 1;
    if (aes_cs_o) begin
      n_acc <= n_acc + 1;
      if (aes_we_o) begin
        if (aes_addr_o == 32'h08) begin
          if (aes_wdata_o[0]) begin
            n_init  <= n_init + 1;
            m_busy  <= 3;
            m_valid <= 1'b0;
          end else if (aes_wdata_o[1]) begin
            m_busy  <= 3;
            m_valid <= 1'b1;
            m_res   <= aes_ref(m_cfg, {m_key[0], m_key[1], m_key[2], m_key[3],
                                       m_key[4], m_key[5], m_key[6], m_key[7]},
                               {m_blk[0], m_blk[1], m_blk[2], m_blk[3]});
          end
        end else if (aes_addr_o == 32'h0A) begin
          m_cfg    <= aes_wdata_o[1:0];
          last_cfg <= aes_wdata_o;
          n_cfg_wr <= n_cfg_wr + 1;
        end else if (aes_addr_o[31:3] == 29'h2) begin
          m_key[aes_addr_o[2:0]] <= aes_wdata_o;
          n_key_wr <= n_key_wr + 1;
        end else if (aes_addr_o[31:2] == 30'h8) begin
          m_blk[aes_addr_o[1:0]] <= aes_wdata_o;
        end
      end else begin
        if (aes_addr_o == 32'h09) begin
          n_status_rd <= n_status_rd + 1;
          aes_rdata_i <= {30'b0, m_valid && m_busy == 0 && !m_stuck, m_busy == 0 && !m_stuck};
        end else if (aes_addr_o[31:2] == 30'hC) begin
          aes_rdata_i <= m_res[{2'd3 - aes_addr_o[1:0], 5'd0} +: 32];
        end else begin
          aes_rdata_i <= 32'h0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic [255:0] k, input logic kl, input logic ed,
                          input logic [127:0] b);
    int t;
    t = 0;
    @(negedge clk_i);
    req_key_i = k; req_keylen_i = kl; req_encdec_i = ed; req_block_i = b;
    req_valid_i = 1'b1;
    while (!req_ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    check_eq("req_accept", {127'b0, req_ready_o}, 128'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output logic [127:0] blk, output logic err);
    int t;
    t = 0;
    while (!rsp_valid_o && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    check_eq("rsp_valid", {127'b0, rsp_valid_o}, 128'd1);
    blk = rsp_block_o;
    err = rsp_err_o;
    if (hold > 0) begin
      repeat (hold) @(negedge clk_i);
      check_eq("hold_valid", {127'b0, rsp_valid_o}, 128'd1);
      check_eq("hold_block", rsp_block_o, blk);
      check_eq("hold_req_ready", {127'b0, req_ready_o}, 128'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check_eq("post_req_ready", {127'b0, req_ready_o}, 128'd1);
    check_eq("post_rsp_valid", {127'b0, rsp_valid_o}, 128'd0);
    check_eq("post_busy", {127'b0, busy_o}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk;
    logic         err;
    logic         cs_seen;
    int           k0, i0, c0, s0, a0, t;

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    cs_seen = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      cs_seen |= aes_cs_o;
    end
    check_eq("rst_req_ready", {127'b0, req_ready_o}, 128'd1);
    check_eq("rst_rsp_valid", {127'b0, rsp_valid_o}, 128'd0);
    check_eq("rst_rsp_block", rsp_block_o, 128'd0);
    check_eq("rst_rsp_err", {127'b0, rsp_err_o}, 128'd0);
    check_eq("rst_busy", {127'b0, busy_o}, 128'd0);
    check_eq("rst_we", {127'b0, aes_we_o}, 128'd0);
    check_eq("rst_addr", {96'b0, aes_addr_o}, 128'd0);
    check_eq("rst_wdata", {96'b0, aes_wdata_o}, 128'd0);
    check_eq("idle_cs_seen", {127'b0, cs_seen}, 128'd0);

    // AES-128 encrypt
    k0 = n_key_wr;
    send_req({K128, 128'h0}, 1'b0, 1'b1, PT);
    check_eq("busy_in_job", {127'b0, busy_o}, 128'd1);
    wait_rsp(0, blk, err);
    check_eq("aes128_block", blk, CT128);
    check_eq("aes128_err", {127'b0, err}, 128'd0);
    check_eq("aes128_key_writes", 128'(n_key_wr - k0), 128'd4);
    check_eq("aes128_config", {96'b0, last_cfg}, 128'h1);

    // AES-256 decrypt
    k0 = n_key_wr;
    send_req(K256, 1'b1, 1'b0, CT256);
    wait_rsp(0, blk, err);
    check_eq("aes256_block", blk, PT);
    check_eq("aes256_err", {127'b0, err}, 128'd0);
    check_eq("aes256_key_writes", 128'(n_key_wr - k0), 128'd8);
    check_eq("aes256_config", {96'b0, last_cfg}, 128'h2);

    // Status never ready: exactly TIMEOUT polls then error response
    m_stuck = 1'b1;
    s0 = n_status_rd;
    send_req({K128, 128'h0}, 1'b0, 1'b1, PT);
    wait_rsp(0, blk, err);
    check_eq("timeout_polls", 128'(n_status_rd - s0), 128'd16);
    check_eq("timeout_err", {127'b0, err}, 128'd1);
    check_eq("timeout_block", blk, 128'd0);
    m_stuck = 1'b0;

    // Back-to-back jobs with the same key; second one also stalls the response
    send_req({K128, 128'h0}, 1'b0, 1'b1, PT);
    wait_rsp(0, blk, err);
    check_eq("b2b_first_block", blk, CT128);
    check_eq("b2b_first_err", {127'b0, err}, 128'd0);
    k0 = n_key_wr; i0 = n_init; c0 = n_cfg_wr;
    send_req({K128, 128'h0}, 1'b0, 1'b1, BLK2);
    wait_rsp(20, blk, err);
    check_eq("b2b_second_block", blk, BLK2 ^ K128);
    check_eq("b2b_config_writes", 128'(n_cfg_wr - c0), 128'd1);
`ifdef AES_SEQ_KEY_CACHE_EN
    check_eq("b2b_key_writes", 128'(n_key_wr - k0), 128'd0);
    check_eq("b2b_inits", 128'(n_init - i0), 128'd0);
`else
    check_eq("b2b_key_writes", 128'(n_key_wr - k0), 128'd4);
    check_eq("b2b_inits", 128'(n_init - i0), 128'd1);
`endif

    // Reset while reading results, then a fresh job
    send_req(K256, 1'b1, 1'b0, CT256);
    t = 0;
    while (!(aes_cs_o && !aes_we_o && aes_addr_o == 32'h30) && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    check_eq("reached_res", {127'b0, aes_cs_o && !aes_we_o && aes_addr_o == 32'h30}, 128'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    a0 = n_acc;
    check_eq("midrst_req_ready", {127'b0, req_ready_o}, 128'd1);
    check_eq("midrst_rsp_valid", {127'b0, rsp_valid_o}, 128'd0);
    check_eq("midrst_busy", {127'b0, busy_o}, 128'd0);
    check_eq("midrst_cs", {127'b0, aes_cs_o}, 128'd0);
    check_eq("midrst_block", rsp_block_o, 128'd0);
    repeat (3) @(negedge clk_i);
    check_eq("midrst_no_access", 128'(n_acc - a0), 128'd0);
    k0 = n_key_wr;
    send_req(K256, 1'b1, 1'b0, CT256);
    wait_rsp(0, blk, err);
    check_eq("after_rst_block", blk, PT);
    check_eq("after_rst_err", {127'b0, err}, 128'd0);
    check_eq("after_rst_key_writes", 128'(n_key_wr - k0), 128'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
